// File: rtl/btn_mode_select.sv
`default_nettype none
// ============================================================================
// Module      : btn_mode_select
// Description : Turns debounced NEXT/PREV/APPLY button levels into a wrapping
//               filter-mode index with hold-to-auto-repeat, and offers the
//               shown mode downstream over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_mode_select #(
    parameter int  NUM_MODES     = 8,
    parameter int  LONG_PRESS    = 12500000,
    parameter int  REPEAT_PERIOD = 2500000,
    localparam int MW            = $clog2(NUM_MODES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_next,
    input  logic          btn_prev,
    input  logic          btn_apply,
    output logic [MW-1:0] mode,
    output logic          step_pulse,
    output logic [MW-1:0] cfg_mode,
    output logic          cfg_valid,
    input  logic          cfg_ready
);

    localparam int c_CNT_MAX = (LONG_PRESS > REPEAT_PERIOD) ? LONG_PRESS : REPEAT_PERIOD;
    localparam int c_CW      = $clog2(c_CNT_MAX);

    localparam logic [c_CW-1:0] c_LP_TERM  = c_CW'(LONG_PRESS - 1);
    localparam logic [c_CW-1:0] c_RP_TERM  = c_CW'(REPEAT_PERIOD - 1);
    localparam logic [MW-1:0]   c_MODE_MAX = MW'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2,
        S_LOCK   = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_dir_up;
    logic [MW-1:0]   r_mode;
    logic            r_step_pulse;
    logic [MW-1:0]   r_cfg_mode;
    logic            r_cfg_valid;

    // Previous samples reset to 1 so a button held through reset needs a
    // release and re-press before it produces an event.
    logic            r_next_q;
    logic            r_prev_q;
    logic            r_apply_q;

    logic            w_next_rise;
    logic            w_prev_rise;
    logic            w_apply_rise;
    logic            w_dir_btn;
    logic            w_other_btn;
    logic [c_CW-1:0] w_term;
    logic [MW-1:0]   w_mode_inc;
    logic [MW-1:0]   w_mode_dec;

    assign w_next_rise  = btn_next  & ~r_next_q;
    assign w_prev_rise  = btn_prev  & ~r_prev_q;
    assign w_apply_rise = btn_apply & ~r_apply_q;

    assign w_dir_btn    = r_dir_up ? btn_next : btn_prev;
    assign w_other_btn  = r_dir_up ? btn_prev : btn_next;
    assign w_term       = (r_state == S_HOLD) ? c_LP_TERM : c_RP_TERM;

    assign w_mode_inc   = (r_mode == c_MODE_MAX) ? '0 : r_mode + MW'(1);
    assign w_mode_dec   = (r_mode == '0) ? c_MODE_MAX : r_mode - MW'(1);

    // Previous-sample registers for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_next_q  <= 1'b1;
            r_prev_q  <= 1'b1;
            r_apply_q <= 1'b1;
        end else begin
            r_next_q  <= btn_next;
            r_prev_q  <= btn_prev;
            r_apply_q <= btn_apply;
        end
    end

    // Step FSM: first step on the press, auto-repeat after a long hold,
    // and a lock-out whenever both step buttons are involved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_dir_up     <= 1'b1;
            r_mode       <= '0;
            r_step_pulse <= 1'b0;
        end else begin
            r_step_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_next_rise && w_prev_rise) begin
                        r_state <= S_LOCK;
                    end else if (w_next_rise) begin
                        if (btn_prev) begin
                            r_state <= S_LOCK;
                        end else begin
                            r_mode       <= w_mode_inc;
                            r_step_pulse <= 1'b1;
                            r_dir_up     <= 1'b1;
                            r_cnt        <= '0;
                            r_state      <= S_HOLD;
                        end
                    end else if (w_prev_rise) begin
                        if (btn_next) begin
                            r_state <= S_LOCK;
                        end else begin
                            r_mode       <= w_mode_dec;
                            r_step_pulse <= 1'b1;
                            r_dir_up     <= 1'b0;
                            r_cnt        <= '0;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD, S_REPEAT: begin
                    // Release wins over everything, so a release on the
                    // terminal count never produces a step.
                    if (!w_dir_btn) begin
                        r_state <= S_IDLE;
                    end else if (w_other_btn) begin
                        r_state <= S_LOCK;
                    end else if (r_cnt == w_term) begin
                        r_mode       <= r_dir_up ? w_mode_inc : w_mode_dec;
                        r_step_pulse <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= S_REPEAT;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_LOCK: begin
                    if (!btn_next && !btn_prev) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Apply handshake: capture the pre-step mode on an APPLY rise when no
    // request is outstanding; rises during a pending request are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg_mode  <= '0;
            r_cfg_valid <= 1'b0;
        end else if (r_cfg_valid) begin
            if (cfg_ready) begin
                r_cfg_valid <= 1'b0;
            end
        end else if (w_apply_rise) begin
            r_cfg_mode  <= r_mode;
            r_cfg_valid <= 1'b1;
        end
    end

    assign mode       = r_mode;
    assign step_pulse = r_step_pulse;
    assign cfg_mode   = r_cfg_mode;
    assign cfg_valid  = r_cfg_valid;

endmodule
`default_nettype wire
